shift_reg_piso: RTL
===================

// Module: shift_reg_piso
// PURPOSE
//   Parallel-in/serial-out shift register with a valid/ready load handshake and framing
//   flags. Upstream stage of shift_reg_sipo: it accepts size-bit words and emits one bit
//   per clock on dataout, which drives shift_reg_sipo.datain. Back-to-back words produce
//   a gap-free bit stream.
// PARAMETERS
//   size       8   word width in bits; must be >= 2
//   LSB_FIRST  1   1: bit 0 is sent first; 0: bit size-1 is sent first
// PORTS
//   clk          in   1     single clock; all state updates on posedge
//   reset        in   1     synchronous, active-high reset
//   load_valid   in   1     load_data is presented for transfer
//   load_ready   out  1     block can accept a word this cycle (combinational)
//   load_data    in   size  parallel word; sampled only when load_valid && load_ready
//   dataout      out  1     serial bit, registered
//   serial_valid out  1     dataout carries a frame bit this cycle, registered
//   serial_last  out  1     dataout is the final bit of the current word
//   busy         out  1     high while in state SHIFT
// BEHAVIOUR
//   State machine: two states, IDLE and SHIFT.
//   Internal registers: shift register sr[size-1:0] and bit counter cnt
//     (width $clog2(size), range 0..size-1).
//   Reset (posedge clk with reset=1) forces:
//     state=IDLE, sr=0, cnt=0, dataout=0, serial_valid=0.
//     Reset overrides every other input in the same cycle.
//   load_ready = (state==IDLE) || (state==SHIFT && cnt==size-1). Not gated by reset.
//   Accept = load_valid && load_ready at a posedge.
//   IDLE:
//     - dataout=0 and serial_valid=0.
//     - On accept: sr<=load_data, cnt<=0, state<=SHIFT.
//     - Latency: the first bit appears on dataout in the cycle after the accept edge.
//   SHIFT:
//     - dataout = sr[0] if LSB_FIRST, else sr[size-1]. serial_valid=1.
//     - Each posedge with cnt<size-1: shift sr one place toward the output end,
//       zero-filling the vacated bit; cnt<=cnt+1.
//     - serial_last = (state==SHIFT && cnt==size-1).
//   Last-bit edge (cnt==size-1):
//     - If accept: reload sr<=load_data and cnt<=0; stay in SHIFT. The next word's
//       first bit follows the previous last bit with no bubble.
//     - Otherwise: state<=IDLE, serial_valid<=0, dataout<=0.
//   load_valid while load_ready=0 (mid-frame): ignored. Upstream must hold the word
//     until it is accepted; the current frame is unaffected.
//   load_data changing without an accept: no effect.
//   Reset mid-frame: the frame is aborted. In the next cycle serial_valid=0, dataout=0
//     and load_ready=1. No residual bits are emitted.
//   Each word occupies exactly size consecutive serial_valid cycles.
// TESTING
//   1. size=8, LSB_FIRST=1; load 8'hA5 from IDLE -> dataout 1,0,1,0,0,1,0,1 on the 8
//      cycles after accept; serial_last only on the 8th; then idle with serial_valid=0.
//   2. Back-to-back 8'hA5 then 8'h3C, with the second load_valid held from the accept
//      of the first -> 16 contiguous serial_valid cycles; bits 9-16 = 0,0,1,1,1,1,0,0.
//   3. load_valid=1 with 8'hFF during bits 2-6 of frame 8'h00 -> load_ready=0, frame
//      bits all 0; 8'hFF is accepted on the last-bit edge and follows immediately.
//   4. Reset pulse at bit 3 of 8'hFF -> next cycle serial_valid=0, dataout=0,
//      load_ready=1, busy=0; a following 8'h01 load sends 1,0,0,0,0,0,0,0.
//   5. LSB_FIRST=0; load 8'h80 -> first bit 1, then seven 0s; serial_last on the 8th.
//   6. Loopback: dataout -> shift_reg_sipo #(.size(8)).datain on the same clk/reset;
//      load 8'hC3 -> sipo dataout == 8'hC3 after the 8th serial bit is clocked in.

Source files
------------

// File: rtl/shift_reg_piso_if.sv
// Load/serial bundle for shift_reg_piso.
// master: upstream word source and serial consumer side; slave: the shift register.
// Signals: load_valid/load_ready/load_data (word handshake), dataout, serial_valid,
//   serial_last, busy (serial side and status).
interface shift_reg_piso_if #(
  parameter int size = 8
);
  logic            load_valid;
  logic            load_ready;
  logic [size-1:0] load_data;
  logic            dataout;
  logic            serial_valid;
  logic            serial_last;
  logic            busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, dataout, serial_valid, serial_last, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, dataout, serial_valid, serial_last, busy
  );
endinterface

// File: rtl/shift_reg_piso.sv
// Purpose: parallel-in/serial-out shifter, one bit per clock, framed by serial_valid/serial_last.
// Latency: first bit on dataout the cycle after the accept edge; words chain with no bubble.
// Backpressure: load_ready low mid-frame; a word is only taken in IDLE or on the last-bit cycle.
// Ports: clk, reset (sync, active-high); bus.slave carries load_valid/load_ready/load_data,
//   dataout, serial_valid, serial_last and busy.
module shift_reg_piso #(
  parameter int size      = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  shift_reg_piso_if.slave  bus
);
  localparam int            CW   = $clog2(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [size-1:0] sr;
  logic [CW-1:0]   cnt;
  logic            dout;
  logic            sval;
  logic [size-1:0] sr_shifted;
  logic            at_last;
  logic            accept;

  // Bit that sits at the output end of a word.
  function automatic logic out_bit(input logic [size-1:0] w);
    return LSB_FIRST ? w[0] : w[size-1];
  endfunction

  always_comb begin
    sr_shifted = LSB_FIRST ? (sr >> 1) : (sr << 1);
  end

  assign at_last = (state == SHIFT) && (cnt == LAST);
  // A new word may land on the last-bit edge so the stream stays gap-free.
  assign bus.load_ready = (state == IDLE) || at_last;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.dataout      = dout;
  assign bus.serial_valid = sval;
  assign bus.serial_last  = at_last;
  assign bus.busy         = (state == SHIFT);

  // dout is registered alongside sr and always mirrors the output end of the
  // value sr takes on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      dout  <= 1'b0;
      sval  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr    <= bus.load_data;
            cnt   <= '0;
            dout  <= out_bit(bus.load_data);
            sval  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            sr   <= sr_shifted;
            cnt  <= cnt + 1'b1;
            dout <= out_bit(sr_shifted);
          end else if (accept) begin
            sr   <= bus.load_data;
            cnt  <= '0;
            dout <= out_bit(bus.load_data);
          end else begin
            state <= IDLE;
            sval  <= 1'b0;
            dout  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
